// File: rtl/multi_axis_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : multi_axis_stepper
//  Purpose  : N-channel stepper pulse coordinator. A single start command
//             latches a step count and direction for every axis; all axes
//             then step in lockstep from one shared phase counter, and the
//             command completes once every axis has run out of steps.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_Clk      : clock
//    i_rst_n    : asynchronous active-low reset
//    i_start    : command strobe, sampled only while idle
//    i_steps    : packed per-axis step counts, axis k at [k*STEP_W +: STEP_W]
//    i_dir      : per-axis direction, latched with the command
//    i_abort    : terminates the move in progress
//    o_step     : step pulse per axis
//    o_dir      : registered direction per axis
//    o_busy     : high from command acceptance until completion
//    o_done     : one-cycle completion pulse
//    o_aborted  : qualifies o_done, high when the move ended by abort
//    o_pos      : (MOTOR_POS_TRACK_EN only) packed signed position per axis,
//                 STEP_W+2 bits each
//  Build option
//    MOTOR_POS_TRACK_EN : adds the o_pos position tracking output
// ============================================================================
module multi_axis_stepper #(
  parameter int N_AXES      = 2,
  parameter int STEP_W      = 15,
  parameter int HALF_PERIOD = 25000,
  parameter int DIR_SETUP   = 50
) (
  input  logic                       i_Clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [N_AXES*STEP_W-1:0]   i_steps,
  input  logic [N_AXES-1:0]          i_dir,
  input  logic                       i_abort,
  output logic [N_AXES-1:0]          o_step,
  output logic [N_AXES-1:0]          o_dir,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_aborted
`ifdef MOTOR_POS_TRACK_EN
  ,
  output logic [N_AXES*(STEP_W+2)-1:0] o_pos
`endif
);

  localparam int PH_MAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] PH_HALF  = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0] PH_SETUP = PH_W'(DIR_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_RUN_HI = 3'd2,
    S_RUN_LO = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [PH_W-1:0]                phase_q, phase_d;
  logic [N_AXES-1:0][STEP_W-1:0]  rem_q, rem_d;
  logic [N_AXES-1:0]              dir_q, dir_d;
  logic                           abort_q, abort_d;
  logic [N_AXES-1:0]              step_q, step_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           aborted_q, aborted_d;

  logic [N_AXES-1:0]              active;
  logic                           phase_end;
  logic                           hi_exit;

  always_comb begin
    for (int k = 0; k < N_AXES; k++) begin
      active[k] = (rem_q[k] != '0);
    end
  end

  assign phase_end = (phase_q == '0);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    abort_d = abort_q;
    hi_exit = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SETUP;
          phase_d = PH_SETUP;
          dir_d   = i_dir;
          abort_d = 1'b0;
          for (int k = 0; k < N_AXES; k++) begin
            rem_d[k] = i_steps[k*STEP_W +: STEP_W];
          end
        end
      end

      S_SETUP, S_RUN_LO, S_RUN_HI: begin
        // An abort drains through one zero-length RUN_LO so that the step
        // output is low for a cycle before the completion pulse. The abort
        // flag stops a held i_abort from re-triggering that drain forever.
        if (i_abort && !abort_q) begin
          state_d = S_RUN_LO;
          phase_d = '0;
          rem_d   = '0;
          abort_d = 1'b1;
        end else if (!phase_end) begin
          phase_d = phase_q - PH_W'(1);
        end else if (state_q == S_RUN_HI) begin
          state_d = S_RUN_LO;
          phase_d = PH_HALF;
          hi_exit = 1'b1;
          for (int k = 0; k < N_AXES; k++) begin
            if (active[k]) begin
              rem_d[k] = rem_q[k] - STEP_W'(1);
            end
          end
        end else if (|active) begin
          state_d = S_RUN_HI;
          phase_d = PH_HALF;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with it.
    // The remaining counts only change on RUN_HI exit, so the current
    // nonzero mask is the right pulse mask whenever RUN_HI is next.
    step_d    = (state_d == S_RUN_HI) ? active : '0;
    busy_d    = (state_d == S_SETUP) || (state_d == S_RUN_HI) ||
                (state_d == S_RUN_LO);
    done_d    = (state_d == S_DONE);
    aborted_d = (state_d == S_DONE) && abort_q;
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      rem_q     <= '0;
      dir_q     <= '0;
      abort_q   <= 1'b0;
      step_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      abort_q   <= abort_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign o_step    = step_q;
  assign o_dir     = dir_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_aborted = aborted_q;

`ifdef MOTOR_POS_TRACK_EN
  // Only a RUN_HI phase that runs to completion counts as a step; a pulse
  // cut short by abort is not added to the position.
  logic [N_AXES-1:0][STEP_W+1:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (hi_exit) begin
      for (int k = 0; k < N_AXES; k++) begin
        if (active[k]) begin
          pos_d[k] = dir_q[k] ? (pos_q[k] + (STEP_W+2)'(1))
                              : (pos_q[k] - (STEP_W+2)'(1));
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign o_pos = pos_q;
`endif

endmodule
`default_nettype wire
